plcp_hdr_ctrl: RTL and testbench
================================

# plcp_hdr_ctrl

Sequences the 802.11b long-PLCP preamble and header onto the 1 Mbps serial bit stream ahead of the scrambler/DBPSK stage. The block emits SYNC, SFD and the SIGNAL/SERVICE/LENGTH fields. It drives the bit-serial CRC-16 engine (1+x^5+x^12+x^16, preset all-ones, complemented output) over the 32 header bits, then shifts the engine's result out as the HEC. Each start request produces one complete 192-bit preamble+header at the default parameters.

## Interface
Parameters:
- SYNC_LEN, 128: number of SYNC bits (all ones, unscrambled at this point); legal range 1..255.
- SFD, 16'hF3A0: start-frame delimiter, sent LSB first.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- bit_en  in  1  one-clk strobe per 1 µs bit period; consecutive strobes at least 2 clk apart.
- start  in  1  request; accepted only when ready=1.
- signal_in  in  8  SIGNAL field, sampled on accepted start.
- service_in  in  8  SERVICE field, sampled on accepted start.
- length_in  in  16  LENGTH field (µs), sampled on accepted start.
- ready  out  1  high in IDLE only.
- bit_out  out  1  current serial bit, registered.
- bit_valid  out  1  high while bit_out carries a preamble/header bit.
- done  out  1  one-clk pulse after the last HEC bit period ends.
- crc_rst  out  1  registered one-clk pulse; ORed with rst at the CRC engine to preset it to 16'hFFFF.
- crc_en  out  1  registered one-clk CRC advance strobe.
- crc_data  out  1  registered bit fed to the CRC engine.
- crc_val  in  16  complemented CRC result from the engine.

## Operation
- States: IDLE, SYNC, SFD, HDR, HEC, DONE.
- IDLE:
  - ready=1.
  - start=1 latches {length_in, service_in, signal_in} into a 32-bit shift register (signal_in[0] at bit 0).
  - On the same edge: crc_rst pulses, bit counter clears, state goes to SYNC.
- Bit counter: 8 bits. On each bit_en in a non-IDLE state, the counter increments and bit_out/bit_valid update on that edge.
- SYNC:
  - Each bit_en drives bit_out=1.
  - After SYNC_LEN strobes, counter clears and state goes to SFD.
- SFD:
  - Each bit_en drives bit_out=SFD[cnt], LSB first.
  - After 16 strobes, state goes to HDR.
- HDR:
  - Each bit_en drives bit_out=hdr[0], shifts the header register right, and registers crc_data=hdr[0] with crc_en=1 for that one clk.
  - After 32 strobes, state goes to HEC.
- HEC:
  - The first bit_en loads a 16-bit shift register from crc_val. bit_out=crc_val[15] on that edge, MSB first.
  - Following strobes shift left.
  - After 16 strobes, state goes to DONE.
- DONE:
  - On the next bit_en, bit_valid drops and done pulses for one clk.
  - State returns to IDLE on that edge.
- crc_en and crc_data are driven only in HDR; crc_en=0 and crc_data=0 otherwise.
- start outside IDLE is ignored; the latched fields are unaffected.
- bit_en in IDLE is ignored; bit_valid stays 0.
- start and bit_en in the same IDLE cycle: start is accepted; that bit_en is not consumed.
- rst at any time:
  - State returns to IDLE and the header/HEC registers clear.
  - The engine resets through the external OR with rst.

## Timing
- Reset values:
  - ready=1.
  - bit_out=0, bit_valid=0, done=0.
  - crc_rst=0, crc_en=0, crc_data=0.
- start to crc_rst: crc_rst is high in the clk following the accepting edge.
- The first bit appears on the first bit_en after acceptance.
- Output bit ordering:
  - SYNC_LEN+64 bit periods total (192 at defaults).
  - bit_out changes only on bit_en edges.
- crc_en is high for exactly 32 clk per frame, each 1 clk after the corresponding HDR bit edge.
- crc_val is sampled at the first HEC bit_en, at least 2 clk after the last crc_en. The minimum bit_en spacing guarantees the engine has settled.
- done is asserted 1 clk after the bit_en that ends the 16th HEC bit period. ready returns on the same edge.

## Test plan
- Reset then idle:
  - Stimulus: hold rst 3 clk, then toggle bit_en for 10 periods.
  - Required: all outputs stay at reset values, ready=1, no crc_en.
- Nominal frame:
  - Stimulus: signal=0x0A, service=0x00, length=0x0040, bit_en every 11 clk, engine connected.
  - Required sequence:
    - 128 ones.
    - Then 0xF3A0 LSB-first (0,0,0,0,0,1,0,1,1,1,0,0,1,1,1,1).
    - Then 0x0A,0x00,0x40,0x00 LSB-first.
    - Then 16 HEC bits MSB-first, equal to the bench golden CRC-16 of those 32 bits.
  - Then done pulses once.
- CRC handshake:
  - Stimulus: same frame as the nominal case, bit_en spacing 2 clk.
  - Required: exactly 32 crc_en pulses, crc_data matching the header bits, crc_rst exactly once at frame start, and the HEC still correct.
- Busy start:
  - Stimulus: start with length=0xFFFF asserted mid-SYNC and mid-HDR.
  - Required: ignored; the frame completes with its original fields.
- Mid-frame reset:
  - Stimulus: assert rst during HDR bit 10, release it, then start a new frame with length=0x1234.
  - Required: bit_valid drops immediately and the new frame emits a full 128-bit SYNC.
  - Required: the HEC matches a fresh CRC of the new header.
- Parameter corner:
  - Stimulus: SYNC_LEN=1, back-to-back frames with start held high.
  - Required: 65 valid bits per frame, and the next frame starts on the clk after done.

Source files
------------

// File: rtl/plcp_hdr_if.sv
// Handshake/bus bundle between the PLCP header sequencer and its environment:
// start request with header fields, serial bit output, and the CRC engine link.
interface plcp_hdr_if;
    logic        bit_en;
    logic        start;
    logic [7:0]  signal_in;
    logic [7:0]  service_in;
    logic [15:0] length_in;
    logic        ready;
    logic        bit_out;
    logic        bit_valid;
    logic        done;
    logic        crc_rst;
    logic        crc_en;
    logic        crc_data;
    logic [15:0] crc_val;

    // Environment side: request source, bit-period timer and CRC engine.
    modport master (
        output bit_en, start, signal_in, service_in, length_in, crc_val,
        input  ready, bit_out, bit_valid, done, crc_rst, crc_en, crc_data
    );

    // Sequencer side.
    modport slave (
        input  bit_en, start, signal_in, service_in, length_in, crc_val,
        output ready, bit_out, bit_valid, done, crc_rst, crc_en, crc_data
    );
endinterface

// File: rtl/plcp_hdr_ctrl.sv
// 802.11b long-PLCP preamble/header sequencer. Emits SYNC, SFD, the 32 header
// bits (SIGNAL/SERVICE/LENGTH, LSB first) and the 16-bit HEC (MSB first) on
// the 1 Mbps serial stream, while feeding the header bits to an external
// bit-serial CRC-16 engine whose complemented result becomes the HEC.
module plcp_hdr_ctrl #(
    parameter int unsigned SYNC_LEN = 128,
    parameter logic [15:0] SFD      = 16'hF3A0
) (
    input logic       clk,
    input logic       rst,
    plcp_hdr_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_SFD, S_HDR, S_HEC, S_DONE
    } state_t;

    localparam logic [7:0] SYNC_LAST = 8'(SYNC_LEN - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic [31:0] hdr;
    logic [15:0] hec;
    logic        ready_q;
    logic        bit_out_q;
    logic        bit_valid_q;
    logic        done_q;
    logic        crc_rst_q;
    logic        crc_en_q;
    logic        crc_data_q;

    // Frame sequencer: advances one bit per bit_en strobe, all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            hdr         <= '0;
            hec         <= '0;
            ready_q     <= 1'b1;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            done_q      <= 1'b0;
            crc_rst_q   <= 1'b0;
            crc_en_q    <= 1'b0;
            crc_data_q  <= 1'b0;
        end else begin
            // Single-clk pulses fall back to zero unless set below.
            crc_rst_q  <= 1'b0;
            crc_en_q   <= 1'b0;
            crc_data_q <= 1'b0;
            done_q     <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A coincident bit_en is deliberately not consumed here.
                    if (bus.start) begin
                        hdr       <= {bus.length_in, bus.service_in, bus.signal_in};
                        crc_rst_q <= 1'b1;
                        cnt       <= '0;
                        ready_q   <= 1'b0;
                        state     <= S_SYNC;
                    end
                end
                S_SYNC: begin
                    if (bus.bit_en) begin
                        bit_out_q   <= 1'b1;
                        bit_valid_q <= 1'b1;
                        if (cnt == SYNC_LAST) begin
                            cnt   <= '0;
                            state <= S_SFD;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                S_SFD: begin
                    if (bus.bit_en) begin
                        bit_out_q   <= SFD[cnt[3:0]];
                        bit_valid_q <= 1'b1;
                        if (cnt == 8'd15) begin
                            cnt   <= '0;
                            state <= S_HDR;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                S_HDR: begin
                    if (bus.bit_en) begin
                        bit_out_q   <= hdr[0];
                        bit_valid_q <= 1'b1;
                        hdr         <= {1'b0, hdr[31:1]};
                        crc_en_q    <= 1'b1;
                        crc_data_q  <= hdr[0];
                        if (cnt == 8'd31) begin
                            cnt   <= '0;
                            state <= S_HEC;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                S_HEC: begin
                    if (bus.bit_en) begin
                        bit_valid_q <= 1'b1;
                        // Engine has settled by the first HEC strobe; capture it then.
                        if (cnt == 8'd0) begin
                            bit_out_q <= bus.crc_val[15];
                            hec       <= {bus.crc_val[14:0], 1'b0};
                        end else begin
                            bit_out_q <= hec[15];
                            hec       <= {hec[14:0], 1'b0};
                        end
                        if (cnt == 8'd15) begin
                            cnt   <= '0;
                            state <= S_DONE;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                S_DONE: begin
                    // Closing strobe ends the last HEC bit period.
                    if (bus.bit_en) begin
                        bit_out_q   <= 1'b0;
                        bit_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        ready_q     <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ready     = ready_q;
    assign bus.bit_out   = bit_out_q;
    assign bus.bit_valid = bit_valid_q;
    assign bus.done      = done_q;
    assign bus.crc_rst   = crc_rst_q;
    assign bus.crc_en    = crc_en_q;
    assign bus.crc_data  = crc_data_q;
endmodule

// File: tb/tb_plcp_hdr_ctrl.sv
// Bench for plcp_hdr_ctrl: two instances (default SYNC_LEN and SYNC_LEN=1),
// each with a bit-serial CRC-16 engine, checked against a frame model whose
// HEC comes from polynomial long division of the header.
module tb_plcp_hdr_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        start = 1'b0;
    logic        bit_en = 1'b0;
    logic [7:0]  sig_v = '0;
    logic [7:0]  svc_v = '0;
    logic [15:0] len_v = '0;

    int n_chk = 0;
    int n_err = 0;

    plcp_hdr_if if0 ();
    plcp_hdr_if if1 ();

    plcp_hdr_ctrl #(.SYNC_LEN(128), .SFD(16'hF3A0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    plcp_hdr_ctrl #(.SYNC_LEN(1),   .SFD(16'hF3A0)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    always #5 clk = ~clk;

    assign if0.bit_en     = bit_en;
    assign if0.start      = start & ~sel;
    assign if0.signal_in  = sig_v;
    assign if0.service_in = svc_v;
    assign if0.length_in  = len_v;
    assign if1.bit_en     = bit_en;
    assign if1.start      = start & sel;
    assign if1.signal_in  = sig_v;
    assign if1.service_in = svc_v;
    assign if1.length_in  = len_v;

    // CRC engines: preset on rst or crc_rst, advance one bit per crc_en.
    logic [15:0] eng0, eng1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) eng0 <= 16'hFFFF;
        else if (if0.crc_rst) eng0 <= 16'hFFFF;
        else if (if0.crc_en) eng0 <= {eng0[14:0], 1'b0} ^ ((eng0[15] ^ if0.crc_data) ? 16'h1021 : 16'h0);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) eng1 <= 16'hFFFF;
        else if (if1.crc_rst) eng1 <= 16'hFFFF;
        else if (if1.crc_en) eng1 <= {eng1[14:0], 1'b0} ^ ((eng1[15] ^ if1.crc_data) ? 16'h1021 : 16'h0);
    end
    assign if0.crc_val = ~eng0;
    assign if1.crc_val = ~eng1;

    logic m_ready, m_bit_out, m_bit_valid, m_done, m_crc_rst, m_crc_en, m_crc_data;
    assign m_ready     = sel ? if1.ready     : if0.ready;
    assign m_bit_out   = sel ? if1.bit_out   : if0.bit_out;
    assign m_bit_valid = sel ? if1.bit_valid : if0.bit_valid;
    assign m_done      = sel ? if1.done      : if0.done;
    assign m_crc_rst   = sel ? if1.crc_rst   : if0.crc_rst;
    assign m_crc_en    = sel ? if1.crc_en    : if0.crc_en;
    assign m_crc_data  = sel ? if1.crc_data  : if0.crc_data;

    // Monitor: free-running tallies; tasks take baselines and look at deltas.
    int   n_crc_rst = 0;
    int   n_done = 0;
    int   n_stray = 0;
    logic crc_q[$];
    logic prev_bit = 1'b0;
    logic en_at_edge = 1'b0;
    always @(posedge clk) en_at_edge <= bit_en;
    always @(negedge clk) begin
        if (m_crc_en) crc_q.push_back(m_crc_data);
        if (m_crc_rst) n_crc_rst++;
        if (m_done) n_done++;
        if (!m_crc_en && m_crc_data) n_stray++;
        if (m_bit_out !== prev_bit && !en_at_edge) n_stray++;
        prev_bit = m_bit_out;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // HEC as remainder of (M(x)*x^16 + preset*x^32) mod G(x), complemented.
    function automatic logic [15:0] golden_hec(input logic [31:0] h);
        logic [47:0] w;
        logic [16:0] g;
        g = 17'h11021;
        w = '0;
        for (int i = 0; i < 32; i++) w[47-i] = h[i];
        w[47:32] = w[47:32] ^ 16'hFFFF;
        for (int i = 47; i >= 16; i--) if (w[i]) w[i -: 17] = w[i -: 17] ^ g;
        return ~w[15:0];
    endfunction

    task automatic strobe(input int gap, output logic v, output logic b, output logic d);
        @(negedge clk); bit_en = 1'b1;
        @(negedge clk); bit_en = 1'b0;
        v = m_bit_valid; b = m_bit_out; d = m_done;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_ready();
        int t = 0;
        while (m_ready !== 1'b1 && t < 5000) begin @(negedge clk); t++; end
        if (t >= 5000) chk("ready_timeout", m_ready, 1);
    endtask

    task automatic check_bits(input string tag, input logic q[$], input int sync_len, input logic [31:0] h);
        logic        e[$];
        logic [15:0] sfd_v, gold, hec_got;
        int          bad;
        sfd_v = 16'hF3A0;
        gold  = golden_hec(h);
        for (int i = 0; i < sync_len; i++) e.push_back(1'b1);
        for (int i = 0; i < 16; i++) e.push_back(sfd_v[i]);
        for (int i = 0; i < 32; i++) e.push_back(h[i]);
        for (int i = 15; i >= 0; i--) e.push_back(gold[i]);
        chk({tag, "_nbits"}, q.size(), e.size());
        bad = -1;
        for (int i = 0; i < q.size() && i < e.size(); i++) if (bad < 0 && q[i] !== e[i]) bad = i;
        chk({tag, "_first_bad_bit"}, bad, -1);
        if (q.size() >= 16) begin
            hec_got = '0;
            for (int i = 0; i < 16; i++) hec_got = {hec_got[14:0], q[q.size()-16+i]};
            chk({tag, "_hec"}, hec_got, gold);
        end
    endtask

    task automatic run_frame(input string tag, input logic s, input logic [7:0] sg, input logic [7:0] sv,
                             input logic [15:0] ln, input int spacing, input int sync_len,
                             input bit busy, input bit en_with_start);
        logic [31:0] h, got32;
        logic        v, b, d;
        logic        q[$];
        int          total, b_rst, b_done, b_stray, b_en;
        h = {ln, sv, sg};
        sel = s;
        wait_ready();
        @(posedge clk);
        b_rst = n_crc_rst; b_done = n_done; b_stray = n_stray; b_en = crc_q.size();
        @(negedge clk);
        sig_v = sg; svc_v = sv; len_v = ln; start = 1'b1; bit_en = en_with_start;
        @(negedge clk);
        start = 1'b0; bit_en = 1'b0;
        sig_v = ~sg; svc_v = ~sv; len_v = ~ln;
        chk({tag, "_accept_ready"}, m_ready, 0);
        chk({tag, "_crc_rst_after_accept"}, m_crc_rst, 1);
        if (en_with_start) chk({tag, "_idle_en_not_consumed"}, m_bit_valid, 0);
        total = sync_len + 64;
        for (int i = 0; i <= total; i++) begin
            if (busy && (i == sync_len / 2 || i == sync_len + 26)) begin
                start = 1'b1; len_v = 16'hFFFF;
                @(negedge clk);
                chk({tag, "_busy_not_ready"}, m_ready, 0);
                start = 1'b0;
            end
            strobe(spacing - 2, v, b, d);
            if (v) q.push_back(b);
            if (i == total) chk({tag, "_done_on_last"}, {d, v, m_ready}, 3'b101);
        end
        repeat (3) @(negedge clk);
        #1;
        check_bits(tag, q, sync_len, h);
        chk({tag, "_done_count"}, n_done - b_done, 1);
        chk({tag, "_crc_rst_count"}, n_crc_rst - b_rst, 1);
        chk({tag, "_crc_en_count"}, crc_q.size() - b_en, 32);
        got32 = '0;
        for (int i = 0; i < 32 && b_en + i < crc_q.size(); i++) got32[i] = crc_q[b_en+i];
        chk({tag, "_crc_data"}, got32, h);
        chk({tag, "_stray_changes"}, n_stray - b_stray, 0);
    endtask

    initial begin
        logic        v, b, d, got_done;
        logic        q[$];
        logic [31:0] h;
        int          b_rst, b_en, b_stray;

        // Reset held three clocks, then idle strobes must do nothing.
        sel = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_outputs", {m_ready, m_bit_out, m_bit_valid, m_done, m_crc_rst, m_crc_en, m_crc_data}, 7'b1000000);
        end
        rst = 1'b0;
        @(posedge clk);
        b_rst = n_crc_rst; b_en = crc_q.size(); b_stray = n_stray;
        for (int i = 0; i < 10; i++) begin
            strobe(2, v, b, d);
            if (i == 0 || i == 9) chk("idle_outputs", {m_ready, m_bit_out, m_bit_valid, m_done, m_crc_rst, m_crc_en, m_crc_data}, 7'b1000000);
        end
        #1;
        chk("idle_crc_activity", (crc_q.size() - b_en) + (n_crc_rst - b_rst) + (n_stray - b_stray), 0);

        run_frame("nominal", 1'b0, 8'h0A, 8'h00, 16'h0040, 11, 128, 1'b0, 1'b1);
        run_frame("crc_hs",  1'b0, 8'h0A, 8'h00, 16'h0040, 2,  128, 1'b0, 1'b0);
        run_frame("busy",    1'b0, 8'h14, 8'h04, 16'h0123, 3,  128, 1'b1, 1'b0);

        // Mid-frame reset during HDR bit 10.
        sel = 1'b0;
        wait_ready();
        @(negedge clk);
        sig_v = 8'h6E; svc_v = 8'h04; len_v = 16'h0555; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 128 + 16 + 11; i++) strobe(1, v, b, d);
        chk("pre_rst_valid", m_bit_valid, 1);
        rst = 1'b1;
        #1;
        chk("rst_drops_valid", {m_bit_valid, m_ready}, 2'b01);
        @(negedge clk);
        rst = 1'b0;
        run_frame("after_rst", 1'b0, 8'($urandom), 8'($urandom), 16'h1234, 5, 128, 1'b0, 1'b0);

        // Randomized frames on both instances.
        for (int k = 0; k < 3; k++)
            run_frame("rand", 1'b0, 8'($urandom), 8'($urandom), 16'($urandom), int'($urandom_range(2, 12)), 128, 1'b0, 1'($urandom_range(0, 1)));
        run_frame("rand_s1", 1'b1, 8'($urandom), 8'($urandom), 16'($urandom), int'($urandom_range(2, 6)), 1, 1'b0, 1'b0);

        // SYNC_LEN=1, start held high: back-to-back frames.
        sel = 1'b1;
        wait_ready();
        @(posedge clk);
        b_rst = n_crc_rst; b_en = crc_q.size();
        @(negedge clk);
        sig_v = 8'h37; svc_v = 8'h80; len_v = 16'hBEEF; start = 1'b1;
        h = {16'hBEEF, 8'h80, 8'h37};
        for (int f = 0; f < 2; f++) begin
            q.delete();
            got_done = 1'b0;
            for (int i = 0; i < 80 && !got_done; i++) begin
                strobe(0, v, b, d);
                if (v) q.push_back(b);
                if (d) got_done = 1'b1;
            end
            if (f == 1) start = 1'b0;
            chk("corner_done_seen", got_done, 1);
            check_bits("corner", q, 1, h);
            if (f == 0) begin
                @(negedge clk);
                chk("corner_restart", {m_crc_rst, m_ready}, 2'b10);
            end
        end
        repeat (4) @(negedge clk);
        #1;
        chk("corner_crc_rst_count", n_crc_rst - b_rst, 2);
        chk("corner_crc_en_count", crc_q.size() - b_en, 64);
        chk("corner_idle_after", m_ready, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
